// File: rtl/channel_merge4.sv
// Four-channel round-robin merger onto one registered valid/ready output, each beat tagged with its source index.
// Optional per-channel accepted-beat counters are built when CHANNEL_MERGE_STATS_EN is defined.
module channel_merge4 #(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  input  logic [3:0]    vld,
  output logic [3:0]    rdy,
  output logic [DW-1:0] dout,
  output logic [1:0]    sel,
  output logic          dout_vld,
  input  logic          dout_rdy
`ifdef CHANNEL_MERGE_STATS_EN
  ,
  output logic [CW-1:0] gnt_cnt0,
  output logic [CW-1:0] gnt_cnt1,
  output logic [CW-1:0] gnt_cnt2,
  output logic [CW-1:0] gnt_cnt3
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr;
  logic [1:0]    gnt;
  logic          gnt_any;
  logic          load;
  logic          take;
  logic [DW-1:0] din_arr [4];

  if (DW < 1 || CW < 1) begin : g_bad_param
    $error("channel_merge4: DW and CW must be at least 1");
  end

  assign din_arr[0] = din0;
  assign din_arr[1] = din1;
  assign din_arr[2] = din2;
  assign din_arr[3] = din3;

  // Search starts one past the last winner; offset 4 wraps back onto ptr itself.
  always_comb begin
    logic [1:0] idx;
    gnt_any = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr + k[1:0];
      if (!gnt_any && vld[idx]) begin
        gnt_any = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign load = (state == EMPTY) || dout_rdy;
  assign take = load && gnt_any;

  // rst_n gates rdy so no source sees a handshake while the block is held in reset.
  always_comb begin
    rdy = '0;
    if (rst_n && take) rdy = 4'b0001 << gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (take) state_nxt = FULL;
      FULL:  if (load && !gnt_any) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    dout_vld = (state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      sel  <= '0;
      ptr  <= 2'd3;
    end else if (take) begin
      dout <= din_arr[gnt];
      sel  <= gnt;
      ptr  <= gnt;
    end
  end

`ifdef CHANNEL_MERGE_STATS_EN
  logic [CW-1:0] cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (take) begin
      if (cnt[gnt] != '1) cnt[gnt] <= cnt[gnt] + 1'b1;
    end
  end

  assign gnt_cnt0 = cnt[0];
  assign gnt_cnt1 = cnt[1];
  assign gnt_cnt2 = cnt[2];
  assign gnt_cnt3 = cnt[3];
`endif

endmodule
